axo32_debug_memseq: RTL and testbench

- Debug memory-access sequencer that sits directly upstream of the core/bus debug override mux.
- Accepts byte-level debug commands from the debug transport: set address, read byte, write byte.
- Produces the mem_addr / mem_re / mem_we / mem_temp strobes that the mux drives onto the memory bus while the core is halted.
- Waits for bus ready with a timeout, returns the read byte or an error, and auto-increments the address after each successful access.

---
 rtl/axo_debug_pkg.sv | 36 +++
 rtl/axo32_debug_memseq.sv | 124 ++++++++++++
 tb/tb_axo32_debug_memseq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/axo_debug_pkg.sv
// Shared encodings for the debug memory sequencer and the xrd register-port sequencer.
// Holds op codes, FSM states, the response record and the timeout counter sizing helper.
package axo_debug_pkg;

  typedef enum logic [1:0] {
    OP_SET_ADDR = 2'd0,
    OP_READ     = 2'd1,
    OP_WRITE    = 2'd2,
    OP_RSVD     = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       err;
  } rsp_t;

  // Wide enough to hold the value TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  // Debug register-port map used by the xrd sequencer.
  localparam logic [1:0] XRD_REG_CTRL   = 2'd0;
  localparam logic [1:0] XRD_REG_STATUS = 2'd1;
  localparam logic [1:0] XRD_REG_ADDR   = 2'd2;
  localparam logic [1:0] XRD_REG_DATA   = 2'd3;
  localparam logic [7:0] XRD_CTRL_HALT  = 8'h01;
  localparam logic [7:0] XRD_CTRL_RUN   = 8'h02;

endpackage

// File: rtl/axo32_debug_memseq.sv
// Debug byte-access sequencer feeding the core/bus debug override mux.
// Takes SET_ADDR/READ/WRITE commands, drives registered bus strobes, returns data or an error.
module axo32_debug_memseq
  import axo_debug_pkg::*;
#(
  parameter int TIMEOUT  = 255,
  parameter bit AUTO_INC = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  input  logic        mem_override,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_temp,
  input  logic [7:0]  mem_rdata,
  output logic        mem_re,
  output logic        mem_we,
  input  logic        mem_ready
);

  localparam int            CW       = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [7:0]    temp_q, temp_d;
  logic          re_q, re_d, we_q, we_d;
  rsp_t          rsp_q, rsp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  op_e           op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_q.data;
  assign rsp_err   = rsp_q.err;
  assign mem_addr  = addr_q;
  assign mem_temp  = temp_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      temp_q  <= '0;
      re_q    <= 1'b0;
      we_q    <= 1'b0;
      rsp_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      temp_q  <= temp_d;
      re_q    <= re_d;
      we_q    <= we_d;
      rsp_q   <= rsp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    temp_d  = temp_q;
    re_d    = re_q;
    we_d    = we_q;
    rsp_d   = rsp_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_SET_ADDR: addr_d = cmd_data;
            OP_READ, OP_WRITE: begin
              if (mem_override) begin
                state_d = ACCESS;
                cnt_d   = '0;
                re_d    = (op == OP_READ);
                we_d    = (op == OP_WRITE);
                if (op == OP_WRITE) temp_d = cmd_data[7:0];
              end else begin
                state_d = RESP;
                rsp_d   = '{data: 8'h00, err: 1'b1};
              end
            end
            default: begin
              state_d = RESP;
              rsp_d   = '{data: 8'h00, err: 1'b1};
            end
          endcase
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // Ready wins over a same-cycle timeout or loss of bus ownership.
        if (mem_ready) begin
          state_d = RESP;
          re_d    = 1'b0;
          we_d    = 1'b0;
          rsp_d   = '{data: (re_q ? mem_rdata : 8'h00), err: 1'b0};
          if (AUTO_INC) addr_d = addr_q + 32'd1;
        end else if (cnt_q == CNT_LAST || !mem_override) begin
          state_d = RESP;
          re_d    = 1'b0;
          we_d    = 1'b0;
          rsp_d   = '{data: 8'h00, err: 1'b1};
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axo32_debug_memseq.sv
// Bench for axo32_debug_memseq: vector table of commands, response scoreboard, memory model.
module tb_axo32_debug_memseq;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_data, mem_addr;
  logic [7:0]  rsp_data, mem_temp;
  logic        mem_override, mem_re, mem_we;
  logic        mem_ready = 1'b0;
  logic [7:0]  mem_rdata = 8'hEE;

  axo32_debug_memseq #(.TIMEOUT(4), .AUTO_INC(1'b1)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .mem_override(mem_override), .mem_addr(mem_addr), .mem_temp(mem_temp),
    .mem_rdata(mem_rdata), .mem_re(mem_re), .mem_we(mem_we), .mem_ready(mem_ready)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic        ovr;
    int          wt;     // strobe cycles before ready; large = never
    logic [7:0]  rd;
    int          hold;   // cycles rsp_ready stays low
    int          drop;   // wait-loop index at which override falls, -1 none
    logic [7:0]  e_data;
    logic        e_err;
    int          e_re;
    int          e_we;
    logic [31:0] e_addr;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t        sb[$];
  vec_t        vt[14];
  int          passed = 0, total = 0;
  logic [31:0] cur_addr = 32'h0;
  logic [7:0]  temp_model = 8'h00;

  // Memory model: raises ready after wait_cfg strobe cycles, counts strobe cycles.
  int          wait_cfg = 0, wc = 0, re_cnt = 0, we_cnt = 0, excl_err = 0;
  logic [7:0]  rdata_cfg = 8'h00;
  logic [31:0] strobe_addr = 32'h0;

  always @(negedge clock) begin
    if (mem_re && mem_we) excl_err <= excl_err + 1;
    if (mem_re || mem_we) begin
      mem_ready <= (wc == wait_cfg);
      mem_rdata <= (wc == wait_cfg) ? rdata_cfg : 8'hEE;
      if (wc == 0) strobe_addr <= mem_addr;
      wc <= wc + 1;
      if (mem_re) re_cnt <= re_cnt + 1;
      if (mem_we) we_cnt <= we_cnt + 1;
    end else begin
      mem_ready <= 1'b0;
      mem_rdata <= 8'hEE;
      wc        <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else passed++;
  endtask

  task automatic run_cmd(input vec_t v);
    int t, lat, re0, we0;
    logic [7:0] d0;
    logic stable;
    exp_t e;
    @(negedge clock);
    re0 = re_cnt; we0 = we_cnt;
    wait_cfg = v.wt; rdata_cfg = v.rd;
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data; mem_override = v.ovr;
    if (v.op != 2'd0) sb.push_back('{d: v.e_data, e: v.e_err});
    if (v.op == 2'd2 && v.ovr) temp_model = v.data[7:0];
    t = 0;
    while (!cmd_ready && t < 50) begin @(negedge clock); t++; end
    if (t >= 50) chk("accept_timeout", t, 0);
    @(negedge clock);
    cmd_valid = 1'b0;
    if (v.op == 2'd0) begin
      chk("set_addr", mem_addr, v.e_addr);
      chk("set_no_rsp", rsp_valid, 0);
      cur_addr = v.e_addr;
      return;
    end
    lat = 0;
    while (!rsp_valid && lat < 100) begin
      if (lat == v.drop) mem_override = 1'b0;
      @(negedge clock);
      lat++;
    end
    chk("rsp_latency", lat, v.e_re + v.e_we);
    stable = 1'b1; d0 = rsp_data;
    for (int i = 0; i < v.hold; i++) begin
      if (!rsp_valid || rsp_data !== d0 || cmd_ready || mem_re || mem_we || mem_addr !== v.e_addr)
        stable = 1'b0;
      @(negedge clock);
    end
    if (v.hold > 0) chk("hold_stable", stable, 1);
    rsp_ready = 1'b1;
    chk("rsp_valid_hs", rsp_valid, 1);
    if (sb.size() == 0) chk("sb_underflow", 1, 0);
    else begin
      e = sb.pop_front();
      chk("rsp_data", rsp_data, e.d);
      chk("rsp_err", rsp_err, e.e);
    end
    chk("re_cycles", re_cnt - re0, v.e_re);
    chk("we_cycles", we_cnt - we0, v.e_we);
    if (v.e_re + v.e_we > 0) chk("strobe_addr", strobe_addr, cur_addr);
    @(negedge clock);
    rsp_ready = 1'b0;
    chk("idle_after_hs", {cmd_ready, rsp_valid}, 2'b10);
    chk("addr_after", mem_addr, v.e_addr);
    chk("mem_temp", mem_temp, temp_model);
    cur_addr = v.e_addr;
  endtask

  initial begin
    vec_t v;
    logic quiet;
    //          op    data           ovr wt    rd     hold drop e_d    err re we e_addr
    vt[0]  = '{2'd0, 32'h0000_1000, 1, 0,    8'h00, 0,   -1,  8'h00, 0,  0, 0, 32'h0000_1000};
    vt[1]  = '{2'd1, 32'h0,         1, 2,    8'hA5, 0,   -1,  8'hA5, 0,  3, 0, 32'h0000_1001};
    vt[2]  = '{2'd0, 32'hFFFF_FFFF, 1, 0,    8'h00, 0,   -1,  8'h00, 0,  0, 0, 32'hFFFF_FFFF};
    vt[3]  = '{2'd2, 32'h0000_003C, 1, 0,    8'h00, 0,   -1,  8'h00, 0,  0, 1, 32'h0000_0000};
    vt[4]  = '{2'd0, 32'h0000_2000, 1, 0,    8'h00, 0,   -1,  8'h00, 0,  0, 0, 32'h0000_2000};
    vt[5]  = '{2'd1, 32'h0,         1, 1000, 8'h11, 0,   -1,  8'h00, 1,  4, 0, 32'h0000_2000};
    vt[6]  = '{2'd1, 32'h0,         0, 0,    8'h22, 0,   -1,  8'h00, 1,  0, 0, 32'h0000_2000};
    vt[7]  = '{2'd3, 32'h0,         1, 0,    8'h33, 0,   -1,  8'h00, 1,  0, 0, 32'h0000_2000};
    vt[8]  = '{2'd1, 32'h0,         1, 0,    8'h77, 10,  -1,  8'h77, 0,  1, 0, 32'h0000_2001};
    vt[9]  = '{2'd2, 32'h0000_0099, 1, 1,    8'h00, 0,   -1,  8'h00, 0,  0, 2, 32'h0000_2002};
    vt[10] = '{2'd2, 32'h0000_0011, 0, 0,    8'h00, 0,   -1,  8'h00, 1,  0, 0, 32'h0000_2002};
    vt[11] = '{2'd2, 32'h0000_005A, 1, 3,    8'h00, 0,   -1,  8'h00, 0,  0, 4, 32'h0000_2003};
    vt[12] = '{2'd1, 32'h0,         1, 1000, 8'h44, 0,   1,   8'h00, 1,  2, 0, 32'h0000_2003};
    vt[13] = '{2'd1, 32'h0,         1, 0,    8'hC3, 0,   -1,  8'hC3, 0,  1, 0, 32'h0000_2004};

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = '0;
    rsp_ready = 1'b0; mem_override = 1'b0;
    repeat (2) @(negedge clock);
    chk("rst_strobes", {mem_re, mem_we}, 2'b00);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_temp", mem_temp, 8'h00);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_data}, 10'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 14; i++) run_cmd(vt[i]);

    // Reset in the middle of a WRITE access.
    v = '{2'd0, 32'h0000_4000, 1, 0, 8'h00, 0, -1, 8'h00, 0, 0, 0, 32'h0000_4000};
    run_cmd(v);
    @(negedge clock);
    wait_cfg = 1000;
    cmd_valid = 1'b1; cmd_op = 2'd2; cmd_data = 32'h0000_00E7; mem_override = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("rstmid_we_high", {mem_we, mem_temp}, 9'h1E7);
    #2 reset = 1'b1;
    #1;
    chk("rstmid_async", {mem_we, mem_re, rsp_valid}, 3'b000);
    chk("rstmid_addr", mem_addr, 32'h0);
    temp_model = 8'h00; cur_addr = 32'h0;
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clock);
      if (rsp_valid || mem_we || mem_re) quiet = 1'b0;
    end
    reset = 1'b0;
    repeat (3) begin
      @(negedge clock);
      if (rsp_valid || mem_we || mem_re) quiet = 1'b0;
    end
    chk("rstmid_no_rsp", quiet, 1);
    v = '{2'd1, 32'h0, 1, 0, 8'h5E, 0, -1, 8'h5E, 0, 1, 0, 32'h0000_0001};
    run_cmd(v);

    chk("strobe_exclusive", excl_err, 0);
    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
